seg_bcd_sched: RTL and testbench

Display scheduler that decides what the 6-digit BCD display shows. It sits between the RTC readout and user-interface logic on one side, and the 24-bit BCD input of the seg_bcd display path on the other. It rotates between time and date, gives one-shot messages priority over both through a req/ack handshake, and blanks one digit periodically to show edit mode.

---
 rtl/seg_bcd_sched.sv | 158 +++++++++++++++
 tb/tb_seg_bcd_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_sched.sv
// Purpose : picks the word shown on the 6-digit BCD display (time/date rotation, one-shot messages, edit blink).
// Latency : seg_bcd_o/src_o are registered, one cycle after the inputs and state they derive from.
// Backpr. : messages use a level req / one-cycle ack handshake; no other flow control.
// Ports   : clk, rst_n (async low) | time_bcd_i, date_bcd_i live views | rotate_en_i
//           msg_req_i/msg_bcd_i -> msg_ack_o | edit_en_i, edit_digit_i | seg_bcd_o, src_o (0 time, 1 date, 2 msg)
module seg_bcd_sched #(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         ROTATE_SEC  = 5,
  parameter int         MSG_HOLD_MS = 2000,
  parameter int         BLINK_MS    = 500,
  parameter logic [3:0] BLANK_CODE  = 4'hf
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] time_bcd_i,
  input  logic [23:0] date_bcd_i,
  input  logic        rotate_en_i,
  input  logic        msg_req_i,
  input  logic [23:0] msg_bcd_i,
  output logic        msg_ack_o,
  input  logic        edit_en_i,
  input  logic [2:0]  edit_digit_i,
  output logic [23:0] seg_bcd_o,
  output logic [1:0]  src_o
);

  localparam int DIV    = CLK_FREQ / 1000;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ROT_MS = ROTATE_SEC * 1000;
  localparam int RW     = $clog2(ROT_MS + 1);
  localparam int HW     = $clog2(MSG_HOLD_MS + 1);
  localparam int BW     = $clog2(BLINK_MS + 1);

  // Encoding doubles as the src code.
  typedef enum logic [1:0] {
    S_TIME = 2'd0,
    S_DATE = 2'd1,
    S_MSG  = 2'd2
  } state_t;

  state_t        state_q, ret_q;
  logic [PW-1:0] pre_q;
  logic [RW-1:0] rot_q;
  logic [HW-1:0] hold_q;
  logic [BW-1:0] blink_q;
  logic          blink_phase_q;
  logic [23:0]   msg_latch_q;
  logic [23:0]   seg_q;
  logic [1:0]    src_q;
  logic          ack_q;

  logic          ms_tick;
  logic          accept;
  logic [23:0]   disp_d;
  logic [1:0]    src_d;

  assign ms_tick = (pre_q == PW'(DIV - 1));
  // A request still high in the ack cycle is not re-accepted until the cycle after.
  assign accept  = msg_req_i && !ack_q;

  assign msg_ack_o = ack_q;
  assign seg_bcd_o = seg_q;
  assign src_o     = src_q;

  always_comb begin
    disp_d = time_bcd_i;
    src_d  = 2'd0;
    case (state_q)
      S_DATE: begin
        disp_d = date_bcd_i;
        src_d  = 2'd1;
      end
      S_MSG: begin
        disp_d = msg_latch_q;
        src_d  = 2'd2;
      end
      default: ;
    endcase
    // Digit 0 is the leftmost nibble; codes 6 and 7 match nothing and never blank.
    if (edit_en_i && (state_q != S_MSG) && !blink_phase_q) begin
      for (int i = 0; i < 6; i++) begin
        if (edit_digit_i == 3'(i)) disp_d[20-4*i +: 4] = BLANK_CODE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_TIME;
      ret_q         <= S_TIME;
      pre_q         <= '0;
      rot_q         <= '0;
      hold_q        <= '0;
      blink_q       <= '0;
      blink_phase_q <= 1'b1;
      msg_latch_q   <= '0;
      seg_q         <= '0;
      src_q         <= 2'd0;
      ack_q         <= 1'b0;
    end else begin
      pre_q <= ms_tick ? '0 : pre_q + PW'(1);
      ack_q <= accept;
      seg_q <= disp_d;
      src_q <= src_d;

      if (accept) begin
        msg_latch_q <= msg_bcd_i;
        hold_q      <= '0;
        state_q     <= S_MSG;
        // A relatch inside S_MSG keeps the original view to return to.
        if (state_q != S_MSG) ret_q <= state_q;
      end else begin
        case (state_q)
          S_MSG: begin
            if (ms_tick) begin
              if (hold_q == HW'(MSG_HOLD_MS - 1)) begin
                state_q <= ret_q;
                hold_q  <= '0;
                rot_q   <= '0;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end
          end
          default: begin
            if (rotate_en_i && !edit_en_i) begin
              if (ms_tick) begin
                if (rot_q == RW'(ROT_MS - 1)) begin
                  rot_q   <= '0;
                  state_q <= (state_q == S_TIME) ? S_DATE : S_TIME;
                end else begin
                  rot_q <= rot_q + RW'(1);
                end
              end
            end else begin
              rot_q <= '0;
            end
          end
        endcase
      end

      if (edit_en_i) begin
        if (ms_tick) begin
          if (blink_q == BW'(BLINK_MS - 1)) begin
            blink_q       <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_q <= blink_q + BW'(1);
          end
        end
      end else begin
        blink_q       <= '0;
        blink_phase_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_bcd_sched.sv
// Purpose : self-checking bench for seg_bcd_sched with a millisecond-level reference model.
// Latency : model predicts the registered outputs one clock after the inputs they depend on.
// Backpr. : drives the message handshake like a well-behaved requester (drops req on ack).
module tb_seg_bcd_sched;

  localparam int CLKS_PER_MS = 10;
  localparam int ROTATE_MS   = 1000;
  localparam int HOLD_MS     = 20;
  localparam int BLINK_HALF  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] time_bcd, date_bcd, msg_bcd;
  logic        rotate_en, msg_req, edit_en;
  logic [2:0]  edit_digit;
  logic        msg_ack;
  logic [23:0] seg_bcd;
  logic [1:0]  src;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  seg_bcd_sched #(
    .CLK_FREQ(10_000), .ROTATE_SEC(1), .MSG_HOLD_MS(20), .BLINK_MS(5), .BLANK_CODE(4'hf)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .time_bcd_i(time_bcd), .date_bcd_i(date_bcd), .rotate_en_i(rotate_en),
    .msg_req_i(msg_req), .msg_bcd_i(msg_bcd), .msg_ack_o(msg_ack),
    .edit_en_i(edit_en), .edit_digit_i(edit_digit),
    .seg_bcd_o(seg_bcd), .src_o(src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle after release %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (time measured in whole ms) ----------------
  int          cyc;          // clock edges since reset release
  int          clk_in_ms;    // clocks elapsed inside the current ms
  int          view;         // 0 time, 1 date
  int          ret_view;
  bit          showing_msg;
  int          view_ms;      // ms the current view has been held
  int          msg_ms;       // ms the current message has been held
  logic [23:0] msg_val;
  int          blink_ms;
  bit          digit_visible;
  logic [23:0] e_seg;
  logic [1:0]  e_src;
  logic        e_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; clk_in_ms = 0; view = 0; ret_view = 0; showing_msg = 0;
      view_ms = 0; msg_ms = 0; msg_val = '0; blink_ms = 0; digit_visible = 1;
      e_seg = '0; e_src = 2'd0; e_ack = 1'b0;
    end else begin
      bit new_ms;
      bit take;
      int d;
      cyc++;
      clk_in_ms++;
      new_ms = (clk_in_ms == CLKS_PER_MS);
      if (new_ms) clk_in_ms = 0;

      // what the display shows is decided from the pre-edge situation
      if (showing_msg) begin
        e_seg = msg_val; e_src = 2'd2;
      end else begin
        e_seg = (view == 1) ? date_bcd : time_bcd;
        e_src = 2'(view);
        d = int'(edit_digit);
        if (edit_en && !digit_visible && d <= 5) e_seg[23-4*d -: 4] = 4'hf;
      end

      take = msg_req && !e_ack;
      if (take) begin
        if (!showing_msg) ret_view = view;
        showing_msg = 1; msg_val = msg_bcd; msg_ms = 0;
      end else if (showing_msg) begin
        if (new_ms) msg_ms++;
        if (msg_ms == HOLD_MS) begin
          showing_msg = 0; view = ret_view; view_ms = 0;
        end
      end else if (rotate_en && !edit_en) begin
        if (new_ms) view_ms++;
        if (view_ms == ROTATE_MS) begin
          view = 1 - view; view_ms = 0;
        end
      end else begin
        view_ms = 0;
      end
      e_ack = take;

      if (edit_en) begin
        if (new_ms) blink_ms++;
        if (blink_ms == BLINK_HALF) begin
          digit_visible = !digit_visible; blink_ms = 0;
        end
      end else begin
        blink_ms = 0; digit_visible = 1;
      end
    end
  end

  // one compare process, every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model seg_bcd", 32'(seg_bcd), 32'(e_seg));
      chk("model src", 32'(src), 32'(e_src));
      chk("model msg_ack", 32'(msg_ack), 32'(e_ack));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 100_000) begin
      @(negedge clk);
      guard++;
    end
    chk("goto reached", 32'(cyc), 32'(n));
  endtask

  task automatic send_msg(input logic [23:0] v);
    int seen = 0;
    msg_bcd = v;
    msg_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (msg_ack) begin
        seen++;
        msg_req = 1'b0;
      end
    end
    msg_req = 1'b0;
    chk("ack pulse count", 32'(seen), 32'd1);
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    time_bcd = 24'h123456; date_bcd = 24'h250619; msg_bcd = '0;
    rotate_en = 1'b1; msg_req = 1'b0; edit_en = 1'b0; edit_digit = 3'd0;

    // 1. reset values, then first word after release
    repeat (3) @(negedge clk);
    chk("reset seg_bcd", 32'(seg_bcd), 32'h0);
    chk("reset src", 32'(src), 32'd0);
    chk("reset msg_ack", 32'(msg_ack), 32'd0);
    cmp_en = 1;
    rst_n = 1'b1;
    goto(1);
    chk("first word", 32'(seg_bcd), 32'h123456);
    chk("first src", 32'(src), 32'd0);

    // 2. rotation every 10000 clocks, frozen while editing
    goto(9995);
    chk("before rotate src", 32'(src), 32'd0);
    goto(10005);
    chk("rotate to date src", 32'(src), 32'd1);
    chk("rotate to date seg", 32'(seg_bcd), 32'h250619);
    goto(20005);
    chk("rotate back src", 32'(src), 32'd0);
    edit_en = 1'b1; edit_digit = 3'd7;
    goto(50005);
    chk("edit freezes rotation", 32'(src), 32'd0);
    chk("digit 7 never blanks", 32'(seg_bcd), 32'h123456);
    edit_en = 1'b0; edit_digit = 3'd0;
    goto(60005);
    chk("date after edit", 32'(src), 32'd1);

    // 3. message from date view
    send_msg(24'h000088);
    goto(60100);
    chk("msg src", 32'(src), 32'd2);
    chk("msg seg", 32'(seg_bcd), 32'h000088);
    goto(60205);
    chk("return to date src", 32'(src), 32'd1);
    chk("return to date seg", 32'(seg_bcd), 32'h250619);
    goto(70100);
    chk("rotate counter restarted", 32'(src), 32'd1);
    goto(70205);
    chk("rotate after msg", 32'(src), 32'd0);

    // 4. relatch 150 clocks into a hold, then a 3-cycle request
    goto(70300);
    send_msg(24'h000088);
    goto(70450);
    send_msg(24'h000099);
    goto(70460);
    chk("relatched seg", 32'(seg_bcd), 32'h000099);
    goto(70640);
    chk("hold restarted", 32'(src), 32'd2);
    goto(70655);
    chk("return after 350", 32'(src), 32'd0);
    chk("return after 350 seg", 32'(seg_bcd), 32'h123456);
    goto(70700);
    acks = 0;
    msg_bcd = 24'h000042; msg_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (msg_ack) acks++;
      if (i == 2) msg_req = 1'b0;
    end
    chk("held req acks", 32'(acks), 32'd2);

    // 5. edit blink
    goto(71000);
    rotate_en = 1'b0; edit_en = 1'b1; edit_digit = 3'd2;
    goto(71030); chk("blink visible", 32'(seg_bcd), 32'h123456);
    goto(71060); chk("blink blank", 32'(seg_bcd), 32'h12F456);
    goto(71090); chk("blink blank late", 32'(seg_bcd), 32'h12F456);
    goto(71110); chk("blink visible again", 32'(seg_bcd), 32'h123456);
    goto(71160); chk("blink blank again", 32'(seg_bcd), 32'h12F456);
    edit_digit = 3'd7;
    goto(71170); chk("digit 7 in blank phase", 32'(seg_bcd), 32'h123456);
    edit_digit = 3'd2;
    goto(71175); chk("digit 2 reblanked", 32'(seg_bcd), 32'h12F456);
    edit_en = 1'b0;
    goto(71176); chk("edit off next edge", 32'(seg_bcd), 32'h123456);
    goto(71200);
    edit_en = 1'b1;
    send_msg(24'h000088);
    goto(71260);
    chk("no blank in msg", 32'(seg_bcd), 32'h000088);

    // 6. asynchronous reset mid-hold
    goto(71300);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset seg", 32'(seg_bcd), 32'h0);
    chk("async reset src", 32'(src), 32'd0);
    chk("async reset ack", 32'(msg_ack), 32'd0);
    repeat (2) @(negedge clk);
    edit_en = 1'b0;
    rst_n = 1'b1;
    goto(1);
    chk("after reset src", 32'(src), 32'd0);
    chk("after reset seg", 32'(seg_bcd), 32'h123456);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (msg_ack) acks++;
    end
    chk("no ack after reset", 32'(acks), 32'd0);
    chk("still time view", 32'(src), 32'd0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
